// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA raster engine.
//   rgb_t      : 24-bit {R,G,B} colour
//   vga_ctl_t  : raw timing controls {act, hs, vs}, positive sense
//   colour constants and the test-pattern bar palette lookup
// Optional feature macro used by the engine: VGA_TESTPAT_EN
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } vga_ctl_t;

    localparam rgb_t BLUE    = 24'h0000FF;
    localparam rgb_t WHITE   = 24'hFFFFFF;
    localparam rgb_t ORANGE  = 24'hFF8000;
    localparam rgb_t YELLOW  = 24'hFFFF00;
    localparam rgb_t GREEN   = 24'h00FF00;
    localparam rgb_t DARK    = 24'h202020;
    localparam rgb_t CYAN    = 24'h00FFFF;
    localparam rgb_t MAGENTA = 24'hFF00FF;
    localparam rgb_t RED     = 24'hFF0000;
    localparam rgb_t BLACK   = 24'h000000;

    // Colour bars, left to right across the visible line.
    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pix_delay.sv
// -----------------------------------------------------------------------------
// vga_pix_delay
// Pixel-rate delay line: DEPTH stages advanced only when i_ce is high.
// DEPTH = 0 degenerates to a straight wire.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous clear, active-low (all stages to 0)
//   i_ce   in   pixel clock-enable
//   i_d    in   W-bit data in
//   o_q    out  W-bit data delayed by DEPTH enabled ticks
// -----------------------------------------------------------------------------
module vga_pix_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, i_ce};
            assign o_q      = i_d;
        end else begin : g_sr
            logic [W-1:0] r_sr [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
                end else if (i_ce) begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_core.sv
// -----------------------------------------------------------------------------
// vga_timing_core
// VGA raster engine: pixel clock-enable, H/V counters, line/frame strobes,
// frame counter, delayed sync/blank, and 1-bit pixel to 24-bit RGB merge.
// Optional feature: define VGA_TESTPAT_EN to replace the pixel merge with
// eight vertical colour bars (pix_on/fg_color/bg_color then ignored).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pix_on              renderer bit for the coordinate issued PIPE_LAT ticks ago
//   fg_color, bg_color  colours for pix_on = 1 / 0
//   pix_ce              one-clk pulse every PIX_DIV clks
//   x, y                coordinate counters (stable between pix_ce pulses)
//   line_start          pulse with pix_ce when x == 0
//   frame_start         pulse with pix_ce when x == 0 and y == 0
//   frame_cnt           frames started since reset (wraps)
//   hsync, vsync        delayed syncs, polarity per HS_POL / VS_POL
//   active              delayed display enable
//   rgb                 pixel colour, zero while not active
// -----------------------------------------------------------------------------
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_DIV  = 2,
    parameter int PIPE_LAT = 1,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_on,
    input  logic [23:0]   fg_color,
    input  logic [23:0]   bg_color,
    output logic          pix_ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [23:0]   rgb
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_pix_ce;
    logic [CW-1:0]    r_x, r_y;
    logic             r_line_start, r_frame_start;
    logic [7:0]       r_frame_cnt;
    logic             r_hsync, r_vsync, r_active;
    rgb_t             r_rgb;

    logic             w_tick;
    logic [CW-1:0]    w_x_next, w_y_next;
    vga_ctl_t         w_ctl_raw, w_ctl_dly;
    rgb_t             w_pix_rgb;

    assign w_tick = (r_div == DIV_W'(PIX_DIV - 1));

    // x/y hold the coordinate presented during a pix_ce cycle and step at the
    // end of it, so the strobes look at the value x/y will hold next cycle.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (r_pix_ce) begin
            if (r_x == CW'(H_TOTAL - 1)) begin
                w_x_next = '0;
                if (r_y == CW'(V_TOTAL - 1)) w_y_next = '0;
                else                         w_y_next = r_y + 1'b1;
            end else begin
                w_x_next = r_x + 1'b1;
            end
        end
    end

    // ---- stage: divider, coordinates, strobes ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_pix_ce      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_div         <= w_tick ? '0 : r_div + 1'b1;
            r_pix_ce      <= w_tick;
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_line_start  <= w_tick && (w_x_next == '0);
            r_frame_start <= w_tick && (w_x_next == '0) && (w_y_next == '0);
            if (w_tick && (w_x_next == '0) && (w_y_next == '0))
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    always_comb begin
        w_ctl_raw     = '0;
        w_ctl_raw.act = (r_x < CW'(H_ACTIVE)) && (r_y < CW'(V_ACTIVE));
        w_ctl_raw.hs  = (r_x >= CW'(HS_FIRST)) && (r_x <= CW'(HS_LAST));
        w_ctl_raw.vs  = (r_y >= VS_FIRST[CW-1:0]) && (r_y <= VS_LAST[CW-1:0]);
    end

    // Timing controls travel at pixel rate so they meet the renderer result.
    vga_pix_delay #(
        .DEPTH (PIPE_LAT),
        .W     ($bits(vga_ctl_t))
    ) u_ctl_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ce  (r_pix_ce),
        .i_d   (w_ctl_raw),
        .o_q   (w_ctl_dly)
    );

`ifdef VGA_TESTPAT_EN
    logic [CW-1:0] w_x_dly;
    logic [CW+2:0] w_x8;
    logic [2:0]    w_bar_idx;
    logic          w_unused_tp;

    // The bar index needs the x that belongs to the delayed pixel.
    vga_pix_delay #(
        .DEPTH (PIPE_LAT),
        .W     (CW)
    ) u_x_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ce  (r_pix_ce),
        .i_d   (r_x),
        .o_q   (w_x_dly)
    );

    assign w_x8        = {w_x_dly, 3'b000};
    assign w_bar_idx   = 3'(w_x8 / (CW+3)'(H_ACTIVE));
    assign w_unused_tp = &{1'b0, pix_on, fg_color, bg_color};

    always_comb begin
        w_pix_rgb = '0;
        if (w_ctl_dly.act) w_pix_rgb = bar_color(w_bar_idx);
    end
`else
    always_comb begin
        w_pix_rgb = '0;
        if (w_ctl_dly.act) w_pix_rgb = pix_on ? fg_color : bg_color;
    end
`endif

    // ---- stage: output register (sync, blank, colour) ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsync  <= ~HS_POL;
            r_vsync  <= ~VS_POL;
            r_active <= 1'b0;
            r_rgb    <= '0;
        end else if (r_pix_ce) begin
            r_hsync  <= w_ctl_dly.hs ? HS_POL : ~HS_POL;
            r_vsync  <= w_ctl_dly.vs ? VS_POL : ~VS_POL;
            r_active <= w_ctl_dly.act;
            r_rgb    <= w_pix_rgb;
        end
    end

    assign pix_ce      = r_pix_ce;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign rgb         = r_rgb;

endmodule
